// File: rtl/sort_pkg.sv
// Shared types and helpers for the sort sequencer slice.
package sort_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Single compare-exchange cell: orders the pair (a, b) by the requested direction.
module sort_cmp_swap #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ascend,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             swap
);

  // Strict compare keeps equal words in place, which makes the sort stable.
  always_comb begin
    swap   = ascend ? (a > b) : (a < b);
    lo_out = swap ? b : a;
    hi_out = swap ? a : b;
  end

endmodule

// File: rtl/sort_sequencer.sv
// Frame buffer that bubble-sorts DEPTH words with one shared compare-exchange cell,
// then streams the sorted frame out.
module sort_sequencer
  import sort_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DEPTH  = 8,
  parameter bit          ASCEND = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int unsigned IW = idx_width(DEPTH);
  localparam logic [IW-1:0] LAST   = IW'(DEPTH - 1);
  localparam logic [IW-1:0] LAST_J = IW'(DEPTH - 2);
  localparam logic [IW-1:0] ONE    = IW'(1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    wr_idx, rd_idx, j, j1, pass;
  logic             swapped;
  logic [WIDTH-1:0] lo, hi;
  logic             swap;
  logic             in_fire, out_fire, pass_end, sort_done;

  assign j1 = j + ONE;

  sort_cmp_swap #(.WIDTH(WIDTH)) u_cmp (
    .a      (mem[j]),
    .b      (mem[j1]),
    .ascend (ASCEND),
    .lo_out (lo),
    .hi_out (hi),
    .swap   (swap)
  );

  always_comb begin
    in_ready  = !rst && (state == LOAD);
    out_valid = !rst && (state == DRAIN);
    busy      = !rst && (state == SORT);
    out_data  = out_valid ? mem[rd_idx] : '0;
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    pass_end  = (j == LAST_J);
    // Early exit looks at this cycle's swap as well as earlier ones in the pass.
    sort_done = pass_end && (!(swapped || swap) || (pass == LAST_J));
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (in_fire && (wr_idx == LAST)) state_nx = SORT;
      SORT:    if (sort_done) state_nx = DRAIN;
      DRAIN:   if (out_fire && (rd_idx == LAST)) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      wr_idx  <= '0;
      rd_idx  <= '0;
      j       <= '0;
      pass    <= '0;
      swapped <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        LOAD: begin
          if (in_fire) begin
            mem[wr_idx] <= in_data;
            if (wr_idx == LAST) begin
              wr_idx  <= '0;
              j       <= '0;
              pass    <= '0;
              swapped <= 1'b0;
            end else begin
              wr_idx <= wr_idx + ONE;
            end
          end
        end
        SORT: begin
          if (swap) begin
            mem[j]  <= lo;
            mem[j1] <= hi;
          end
          if (pass_end) begin
            if (!sort_done) begin
              j       <= '0;
              pass    <= pass + ONE;
              swapped <= 1'b0;
            end
          end else begin
            j       <= j1;
            swapped <= swapped || swap;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            wr_idx <= '0;
            rd_idx <= (rd_idx == LAST) ? '0 : rd_idx + ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_sequencer.sv
// Scoreboard bench: drivers push expected sorted words, per-instance monitors pop on output handshakes.
module tb_sort_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Instance A: DEPTH=4 ascending
  logic rst_a, iv_a, ir_a, ov_a, or_a, busy_a;
  logic [3:0] id_a, od_a;
  // Instance B: DEPTH=4 descending; instance C: DEPTH=8 ascending
  logic rst_bc, iv_b, ir_b, ov_b, or_b, busy_b;
  logic [3:0] id_b, od_b;
  logic iv_c, ir_c, ov_c, or_c, busy_c;
  logic [3:0] id_c, od_c;

  sort_sequencer #(.WIDTH(4), .DEPTH(4), .ASCEND(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
    .out_valid(ov_a), .out_ready(or_a), .out_data(od_a), .busy(busy_a));

  sort_sequencer #(.WIDTH(4), .DEPTH(4), .ASCEND(1'b0)) dut_b (
    .clk(clk), .rst(rst_bc), .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
    .out_valid(ov_b), .out_ready(or_b), .out_data(od_b), .busy(busy_b));

  sort_sequencer #(.WIDTH(4), .DEPTH(8), .ASCEND(1'b1)) dut_c (
    .clk(clk), .rst(rst_bc), .in_valid(iv_c), .in_ready(ir_c), .in_data(id_c),
    .out_valid(ov_c), .out_ready(or_c), .out_data(od_c), .busy(busy_c));

  // Standalone compare-exchange cell for the equal-word (stability) cases
  logic [3:0] cs_a, cs_b, cs_lo, cs_hi;
  logic cs_asc, cs_swap;
  sort_cmp_swap #(.WIDTH(4)) u_cs (
    .a(cs_a), .b(cs_b), .ascend(cs_asc), .lo_out(cs_lo), .hi_out(cs_hi), .swap(cs_swap));

  logic [3:0] qa[$], qb[$], qc[$];

  // Monitor A: order, stall stability, in_ready low while draining
  logic [3:0] held_a;
  bit stalled_a = 0;
  always @(negedge clk) begin
    if (!rst_a && ov_a) begin
      chk("a_inready_in_drain", int'(ir_a), 0);
      if (stalled_a) chk("a_stall_hold", int'(od_a), int'(held_a));
      if (or_a) begin
        if (qa.size() == 0) chk("a_unexpected_out", int'(od_a), -1);
        else chk("a_out", int'(od_a), int'(qa.pop_front()));
      end
    end
    stalled_a = !rst_a && ov_a && !or_a;
    held_a    = od_a;
  end

  always @(negedge clk) begin
    if (!rst_bc && ov_b && or_b) begin
      if (qb.size() == 0) chk("b_unexpected_out", int'(od_b), -1);
      else chk("b_out", int'(od_b), int'(qb.pop_front()));
    end
  end

  int popc = 0;
  bit expect_ready_c = 0;
  always @(negedge clk) begin
    if (expect_ready_c) begin
      chk("c_ready_after_drain", int'(ir_c), 1);
      expect_ready_c = 0;
    end
    if (!rst_bc && ov_c && or_c) begin
      if (qc.size() == 0) chk("c_unexpected_out", int'(od_c), -1);
      else chk("c_out", int'(od_c), int'(qc.pop_front()));
      popc++;
      if (popc % 8 == 0) expect_ready_c = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [3:0] v[4], input bit push, input logic [3:0] e[4]);
    int t;
    if (push) for (int i = 0; i < 4; i++) qa.push_back(e[i]);
    for (int i = 0; i < 4; i++) begin
      iv_a = 1'b1;
      id_a = v[i];
      t = 0;
      while (!ir_a && t < 100) begin tick(); t++; end
      chk("a_load_wait", int'(t < 100), 1);
      tick();
    end
    iv_a = 1'b0;
  endtask

  // Called on the cycle right after the final input handshake (cycle 1)
  task automatic lat_a(input int exp_lat, input int exp_busy);
    int cyc, bc;
    cyc = 1;
    bc = 0;
    while (!ov_a && cyc < 100) begin
      if (busy_a) bc++;
      tick();
      cyc++;
    end
    chk("a_latency", cyc, exp_lat);
    chk("a_busy_cycles", bc, exp_busy);
  endtask

  task automatic drain_a(input bit stall);
    int k;
    bit pat[3];
    pat = '{1'b1, 1'b0, 1'b0};
    k = 0;
    while (qa.size() > 0 && k < 100) begin
      or_a = stall ? pat[k % 3] : 1'b1;
      tick();
      k++;
    end
    chk("a_drain_done", int'(qa.size()), 0);
    chk("a_ready_after_drain", int'(ir_a), 1);
    or_a = 1'b1;
  endtask

  initial begin
    int t;
    logic [3:0] vb[4];
    logic [3:0] w[8];
    logic [3:0] s[8];
    logic [3:0] tmp;
    rst_a = 1; rst_bc = 1;
    iv_a = 0; id_a = '0; or_a = 1;
    iv_b = 0; id_b = '0; or_b = 1;
    iv_c = 0; id_c = '0; or_c = 1;
    cs_a = '0; cs_b = '0; cs_asc = 1'b1;
    tick(); tick();
    chk("rst_in_ready", int'(ir_a), 0);
    chk("rst_out_valid", int'(ov_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_out_data", int'(od_a), 0);
    rst_a = 0; rst_bc = 0;
    tick();
    chk("load_in_ready", int'(ir_a), 1);

    // Compare cell: equal words never swap in either direction
    cs_a = 4'd5; cs_b = 4'd5; cs_asc = 1'b1; #1;
    chk("cs_eq_asc_swap", int'(cs_swap), 0);
    cs_asc = 1'b0; #1;
    chk("cs_eq_desc_swap", int'(cs_swap), 0);
    cs_a = 4'd7; cs_b = 4'd3; cs_asc = 1'b1; #1;
    chk("cs_asc_swap", int'(cs_swap), 1);
    chk("cs_asc_lo", int'(cs_lo), 3);
    chk("cs_asc_hi", int'(cs_hi), 7);
    cs_a = 4'd3; cs_b = 4'd15; cs_asc = 1'b0; #1;
    chk("cs_desc_swap", int'(cs_swap), 1);
    chk("cs_desc_lo", int'(cs_lo), 15);
    tick();

    // 1: already sorted, single pass
    load_a('{4'd1, 4'd2, 4'd3, 4'd4}, 1, '{4'd1, 4'd2, 4'd3, 4'd4});
    lat_a(4, 3);
    drain_a(0);

    // 2: reversed, worst case
    load_a('{4'd4, 4'd3, 4'd2, 4'd1}, 1, '{4'd1, 4'd2, 4'd3, 4'd4});
    lat_a(10, 9);
    drain_a(0);

    // 4: stalled drain
    load_a('{4'd9, 4'd7, 4'd9, 4'd2}, 1, '{4'd2, 4'd7, 4'd9, 4'd9});
    lat_a(10, 9);
    drain_a(1);

    // 5: reset during SORT pass 1 aborts the frame
    load_a('{4'd4, 4'd3, 4'd2, 4'd1}, 0, '{4'd0, 4'd0, 4'd0, 4'd0});
    tick(); tick(); tick();
    chk("pre_abort_busy", int'(busy_a), 1);
    rst_a = 1;
    #1;
    chk("abort_rst_busy", int'(busy_a), 0);
    chk("abort_rst_in_ready", int'(ir_a), 0);
    tick();
    rst_a = 0;
    #1;
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_out_valid", int'(ov_a), 0);
    chk("abort_in_ready", int'(ir_a), 1);
    load_a('{4'd0, 4'd5, 4'd5, 4'd1}, 1, '{4'd0, 4'd1, 4'd5, 4'd5});
    lat_a(10, 9);
    drain_a(0);

    // 3: descending instance
    vb = '{4'd3, 4'd15, 4'd0, 4'd15};
    qb.push_back(4'd15); qb.push_back(4'd15); qb.push_back(4'd3); qb.push_back(4'd0);
    for (int i = 0; i < 4; i++) begin
      iv_b = 1'b1;
      id_b = vb[i];
      t = 0;
      while (!ir_b && t < 100) begin tick(); t++; end
      chk("b_load_wait", int'(t < 100), 1);
      tick();
    end
    iv_b = 1'b0;
    t = 0;
    while (qb.size() > 0 && t < 100) begin tick(); t++; end
    chk("b_drain_done", int'(qb.size()), 0);

    // 6: back-to-back DEPTH=8 frames with in_valid held high
    iv_c = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) begin
        w[i] = 4'($urandom_range(0, 15));
        s[i] = w[i];
      end
      for (int i = 1; i < 8; i++)
        for (int k = i; k > 0; k--)
          if (s[k-1] > s[k]) begin tmp = s[k]; s[k] = s[k-1]; s[k-1] = tmp; end
      for (int i = 0; i < 8; i++) qc.push_back(s[i]);
      for (int i = 0; i < 8; i++) begin
        id_c = w[i];
        t = 0;
        while (!ir_c && t < 200) begin tick(); t++; end
        chk("c_load_wait", int'(t < 200), 1);
        tick();
      end
    end
    t = 0;
    while (qc.size() > 0 && t < 200) begin tick(); t++; end
    iv_c = 1'b0;
    chk("c_drain_done", int'(qc.size()), 0);
    tick(); tick();

    chk("a_queue_empty", int'(qa.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
